// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: round-robin arbiter granting one requester at a time write access to a shared register
module dff_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_data,
    input  logic                   i_freeze,
    output logic [N_REQ-1:0]       o_gnt,
    output logic [N_REQ-1:0]       o_done,
    output logic [WIDTH-1:0]       o_data,
    output logic [2:0]             o_last_id,
    output logic                   o_busy
);
    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;
    state_t state, state_nxt;
    logic [2:0] ptr, sel, win;
    logic [3:0] sum;
    logic [7:0] req8;
    logic [N_REQ*WIDTH-1:0] data_sh;
    logic start, commit;
    assign req8    = 8'(i_req);
    assign start   = (state == IDLE) && !i_freeze && |i_req;
    assign commit  = (state == WRITE) && req8[sel];
    assign data_sh = i_data >> (32'(sel) * WIDTH);
    assign o_busy  = (state != IDLE);
    // Scan from the highest offset down so the first set bit at or after ptr wins
    always_comb begin
        win = '0;
        sum = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + 4'(k);
            sum = (sum >= 4'(N_REQ)) ? sum - 4'(N_REQ) : sum;
            if (req8[sum[2:0]]) win = sum[2:0];
        end
    end
    always_comb begin
        state_nxt = state;
        if (start) state_nxt = WRITE;
        else if (state == WRITE) state_nxt = commit ? ACK : IDLE;
        else if (state == ACK) state_nxt = IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr       <= '0;
            sel       <= '0;
            o_gnt     <= '0;
            o_done    <= '0;
            o_data    <= '0;
            o_last_id <= '0;
        end else begin
            if (start) begin
                sel   <= win;
                o_gnt <= N_REQ'(1) << win;
            end
            if (state == WRITE) begin
                o_gnt <= '0;
                if (commit) begin
                    o_data    <= data_sh[WIDTH-1:0];
                    o_last_id <= sel;
                    o_done    <= N_REQ'(1) << sel;
                end
            end
            if (state == ACK) begin
                o_done <= '0;
                ptr    <= (sel == 3'(N_REQ - 1)) ? 3'd0 : sel + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_dff_write_arbiter.sv
// tb_dff_write_arbiter: directed scenarios plus randomized transactions against a transaction-level model
module tb_dff_write_arbiter;
    localparam int N = 4;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_freeze = 1'b0;
    logic [3:0]  i_req = '0;
    logic [31:0] i_data = '0;
    logic [3:0]  o_gnt, o_done;
    logic [7:0]  o_data;
    logic [2:0]  o_last_id;
    logic        o_busy;
    int          checks = 0;
    int          errors = 0;
    int          m_ptr = 0;
    int          m_last = 0;
    logic [7:0]  m_data = '0;

    dff_write_arbiter #(.N_REQ(N), .WIDTH(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_data(i_data),
        .i_freeze(i_freeze), .o_gnt(o_gnt), .o_done(o_done), .o_data(o_data),
        .o_last_id(o_last_id), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_outs(input string tag);
        check({tag, "_gnt"}, 32'(o_gnt), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_data"}, 32'(o_data), 32'(m_data));
        check({tag, "_last"}, 32'(o_last_id), 32'(m_last));
    endtask

    // Pull reset low between edges, confirm outputs clear before any edge, then release after one edge
    task automatic do_reset(input logic [3:0] req_at_release);
        #2 i_rst_n = 1'b0;
        #1;
        m_ptr = 0;
        m_last = 0;
        m_data = '0;
        idle_outs("rst_async");
        tick;
        idle_outs("rst_held");
        i_req = req_at_release;
        i_rst_n = 1'b1;
    endtask

    // One arbitration attempt starting from IDLE: winner is the first requester at or after ptr
    task automatic txn(input logic [3:0] r, input logic [31:0] dv, input bit abort, input bit frz);
        int w;
        w = -1;
        i_req = r;
        i_data = dv;
        i_freeze = 1'b0;
        for (int k = 0; k < N; k++)
            if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        tick;
        if (w < 0) begin
            idle_outs("noreq");
            return;
        end
        check("grant", 32'(o_gnt), 32'(1 << w));
        check("grant_done", 32'(o_done), 32'd0);
        check("grant_busy", 32'(o_busy), 32'd1);
        check("grant_data", 32'(o_data), 32'(m_data));
        i_freeze = frz;
        if (abort) i_req[w] = 1'b0;
        tick;
        if (abort) begin
            idle_outs("abort");
            return;
        end
        m_data = dv[w*8 +: 8];
        m_last = w;
        check("done", 32'(o_done), 32'(1 << w));
        check("done_gnt", 32'(o_gnt), 32'd0);
        check("done_busy", 32'(o_busy), 32'd1);
        check("done_data", 32'(o_data), 32'(m_data));
        check("done_last", 32'(o_last_id), 32'(m_last));
        tick;
        m_ptr = (w + 1) % N;
        idle_outs("ack_exit");
    endtask

    initial begin
        do_reset(4'b0000);
        // single write from requester 2, then ptr=3 shows in the next winner
        txn(4'b0100, 32'h00A5_0000, 1'b0, 1'b0);
        check("single_data", 32'(o_data), 32'hA5);
        check("single_last", 32'(o_last_id), 32'd2);
        txn(4'b1001, 32'h1122_3344, 1'b0, 1'b0);
        check("ptr3_winner", 32'(o_last_id), 32'd3);
        // fairness: all requesting, back-to-back completions 0,1,2,3,0
        do_reset(4'b0000);
        for (int i = 0; i < 5; i++) begin
            txn(4'b1111, 32'h4433_2211, 1'b0, 1'b0);
            check("fair_order", 32'(o_last_id), 32'(i % N));
        end
        // abort of requester 1, then search restarts at the unchanged ptr
        txn(4'b0010, 32'h0000_7700, 1'b1, 1'b0);
        txn(4'b1111, 32'h8877_6655, 1'b0, 1'b0);
        check("after_abort", 32'(o_last_id), 32'd1);
        // freeze blocks grants while idle
        i_req = 4'b0001;
        i_freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            idle_outs("freeze");
        end
        // freeze raised mid-WRITE does not stop the write
        txn(4'b0001, 32'h0000_00C3, 1'b0, 1'b1);
        check("freeze_mid", 32'(o_data), 32'hC3);
        // reset pulled mid-WRITE discards the transaction; release with req[3] held
        i_freeze = 1'b0;
        i_req = 4'b0010;
        tick;
        check("pre_rst_gnt", 32'(o_gnt), 32'b0010);
        do_reset(4'b1000);
        txn(4'b1000, 32'h5A00_0000, 1'b0, 1'b0);
        check("post_rst_data", 32'(o_data), 32'h5A);
        // randomized transactions
        for (int i = 0; i < 60; i++) begin
            if ($urandom % 5 == 0) begin
                i_req = 4'($urandom_range(1, 15));
                i_freeze = 1'b1;
                tick;
                idle_outs("rnd_freeze");
            end
            txn(4'($urandom), $urandom, ($urandom % 4) == 0, 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dff_write_arbiter.md
DFF_WRITE_ARBITER -- requirements
Module: dff_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 8, width of the shared data register.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_clk, input, 1, single clock; all state changes on the rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_req, input, N_REQ, per-requester write request; level, held until o_done.
- i_data, input, N_REQ*WIDTH, write data; requester k uses bits [k*WIDTH +: WIDTH].
- i_freeze, input, 1, when high, blocks new grants.
- o_gnt, output, N_REQ, registered one-hot grant, high for the WRITE cycle.
- o_done, output, N_REQ, registered one-hot write-complete pulse, high for the ACK cycle.
- o_data, output, WIDTH, shared register contents.
- o_last_id, output, 3, index of the last requester that completed a write.
- o_busy, output, 1, high whenever the state is not IDLE.
REQ-003 The block SHALL have exactly one clock and one reset. The reset is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have three states: IDLE, WRITE, ACK.
REQ-005 IDLE -> WRITE SHALL occur at a rising edge where i_freeze=0 and i_req!=0.
- On that edge: latch the winner into sel, set o_gnt[sel]=1.
REQ-006 The winner SHALL be chosen round-robin.
- Search starts at pointer ptr and wraps modulo N_REQ.
- The first set i_req bit wins.
REQ-007 If i_req[sel]=1 at the WRITE-exit edge:
- o_data <= i_data slice sel; o_last_id <= sel.
- o_gnt <= 0; o_done[sel] <= 1; state -> ACK.
REQ-008 If i_req[sel]=0 at the WRITE-exit edge (abort):
- o_data, o_last_id and ptr are unchanged; no o_done.
- o_gnt <= 0; state -> IDLE.
REQ-009 ACK -> IDLE SHALL occur unconditionally after one cycle.
- On that edge: o_done <= 0; ptr <= (sel+1) mod N_REQ.
REQ-010 Timing and throughput:
- o_data SHALL update exactly 2 edges after the request is first sampled in IDLE.
- Maximum throughput SHALL be one write per 3 cycles.
REQ-011 o_gnt and o_done SHALL each be zero or one-hot. They SHALL never be high in the same cycle.
REQ-012 i_freeze SHALL affect only the IDLE->WRITE decision.
- A transaction already in WRITE or ACK SHALL complete normally.
REQ-013 The only requirement on i_req changes outside IDLE is that i_req[sel] be sampled at the WRITE exit.
- A requester still asserting i_req at the ACK->IDLE edge SHALL be re-arbitrated as a new request.
REQ-014 o_data SHALL change only per REQ-007; it SHALL hold its value otherwise.
REQ-015 ptr SHALL advance only on completed writes, never on aborts.
REQ-016 o_busy SHALL be combinational: (state != IDLE).

Reset
REQ-017 i_rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, ptr=0, sel=0.
- o_gnt=0, o_done=0, o_data=0, o_last_id=0, o_busy=0.
REQ-018 Reset asserted during WRITE or ACK SHALL discard the transaction: no o_data update, no o_done pulse.
REQ-019 After i_rst_n deasserts, the first arbitration SHALL occur at the first rising edge with i_rst_n=1.

Verification
REQ-020 The bench SHALL cover these scenarios (N_REQ=4, WIDTH=8):
- Single write: req[2]=1, data2=8'hA5 -> gnt[2] one cycle, then done[2] one cycle; o_data=8'hA5, o_last_id=2, ptr=3.
- Fairness: req=4'b1111 held, distinct data per requester, after reset -> completion order 0,1,2,3,0, with 3-cycle spacing.
- Abort: req[1] dropped during its gnt cycle -> no done[1]; o_data unchanged; the next grant again starts search at the old ptr.
- Freeze: i_freeze=1 with req[0]=1 for 5 cycles -> no gnt, o_busy=0. Freeze raised during WRITE -> that write still completes.
- Async reset: i_rst_n pulled low mid-WRITE between clock edges -> all outputs 0 before the next edge, no done pulse.
- Post-reset: i_rst_n released with req[3]=1 -> gnt[3] at the first edge; o_data=data3 two edges later.
